// File: rtl/icb_dbus_splitter.sv
// ---------------------------------------------------------------------------
// icb_dbus_splitter
//
// Purpose:
//   1-to-2 ICB splitter sitting between the core's data ICB master and its
//   two slaves. Slave 0 is the data SRAM controller, slave 1 the peripheral
//   bus. Each command address is decoded and the command is routed to one
//   slave. Because responses must come back in command order, the target of
//   every accepted command is remembered in a small in-order FIFO. The head of
//   that FIFO decides which slave's response is passed back to the master.
//   Addresses that hit neither region go to an internal error slave that
//   answers with err = 1 and rdata = 0.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   s_icb_cmd_*         command channel from the master (addr/read/wdata/wmask/valid/ready)
//   s_icb_rsp_*         response channel to the master (rdata/err/valid/ready)
//   m0_icb_cmd_*        command channel to slave 0 (data SRAM)
//   m0_icb_rsp_*        response channel from slave 0
//   m1_icb_cmd_*        command channel to slave 1 (peripheral bus)
//   m1_icb_rsp_*        response channel from slave 1
// ---------------------------------------------------------------------------
module icb_dbus_splitter #(
    parameter logic [31:0] m0_baseaddr      = 32'h0000_0000,
    parameter int unsigned m0_addr_range    = 16384,
    parameter logic [31:0] m1_baseaddr      = 32'h4000_0000,
    parameter int unsigned m1_addr_range    = 65536,
    parameter int unsigned outstanding_n    = 4,
    parameter int unsigned simulation_delay = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] s_icb_cmd_addr,
    input  logic        s_icb_cmd_read,
    input  logic [31:0] s_icb_cmd_wdata,
    input  logic [3:0]  s_icb_cmd_wmask,
    input  logic        s_icb_cmd_valid,
    output logic        s_icb_cmd_ready,
    output logic [31:0] s_icb_rsp_rdata,
    output logic        s_icb_rsp_err,
    output logic        s_icb_rsp_valid,
    input  logic        s_icb_rsp_ready,

    output logic [31:0] m0_icb_cmd_addr,
    output logic        m0_icb_cmd_read,
    output logic [31:0] m0_icb_cmd_wdata,
    output logic [3:0]  m0_icb_cmd_wmask,
    output logic        m0_icb_cmd_valid,
    input  logic        m0_icb_cmd_ready,
    input  logic [31:0] m0_icb_rsp_rdata,
    input  logic        m0_icb_rsp_err,
    input  logic        m0_icb_rsp_valid,
    output logic        m0_icb_rsp_ready,

    output logic [31:0] m1_icb_cmd_addr,
    output logic        m1_icb_cmd_read,
    output logic [31:0] m1_icb_cmd_wdata,
    output logic [3:0]  m1_icb_cmd_wmask,
    output logic        m1_icb_cmd_valid,
    input  logic        m1_icb_cmd_ready,
    input  logic [31:0] m1_icb_rsp_rdata,
    input  logic        m1_icb_rsp_err,
    input  logic        m1_icb_rsp_valid,
    output logic        m1_icb_rsp_ready
);

    localparam int unsigned PTR_W = $clog2(outstanding_n);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Target id stored per outstanding command; TGT_ERR is the internal
    // error slave that answers addresses outside both regions.
    typedef enum logic [1:0] {
        TGT_M0  = 2'd0,
        TGT_M1  = 2'd1,
        TGT_ERR = 2'd2
    } target_e;

    // The register model is cycle-accurate with no intra-cycle delay, so
    // simulation_delay has no effect here; it is kept so existing
    // instantiations that override it still elaborate.
    if (simulation_delay > 32'd1000) begin : g_sim_delay_unused
    end

    logic [31:0]      off0;
    logic [31:0]      off1;
    logic             hit0;
    logic             hit1;
    target_e          cmd_tgt;

    target_e          fifo_q [outstanding_n];
    target_e          fifo_d [outstanding_n];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    target_e          head;

    // Address decode. The offset compare is a single unsigned subtraction,
    // so an address below the base wraps to a huge offset and misses.
    // Slave 0 wins if the regions ever overlap.
    always_comb begin
        off0    = s_icb_cmd_addr - m0_baseaddr;
        off1    = s_icb_cmd_addr - m1_baseaddr;
        hit0    = off0 < 32'(m0_addr_range);
        hit1    = off1 < 32'(m1_addr_range);
        cmd_tgt = TGT_ERR;
        if (hit0) begin
            cmd_tgt = TGT_M0;
        end else if (hit1) begin
            cmd_tgt = TGT_M1;
        end
    end

    // Command payload is broadcast to both slaves; only valid is steered.
    assign m0_icb_cmd_addr  = s_icb_cmd_addr;
    assign m0_icb_cmd_read  = s_icb_cmd_read;
    assign m0_icb_cmd_wdata = s_icb_cmd_wdata;
    assign m0_icb_cmd_wmask = s_icb_cmd_wmask;
    assign m1_icb_cmd_addr  = s_icb_cmd_addr;
    assign m1_icb_cmd_read  = s_icb_cmd_read;
    assign m1_icb_cmd_wdata = s_icb_cmd_wdata;
    assign m1_icb_cmd_wmask = s_icb_cmd_wmask;

    // Command steering. A full target FIFO blocks every command, even in a
    // cycle where a response pops, so the ready path never depends on the
    // response handshake. The error slave is always ready.
    always_comb begin
        full             = (count_q == CNT_W'(outstanding_n));
        m0_icb_cmd_valid = s_icb_cmd_valid & (cmd_tgt == TGT_M0) & ~full;
        m1_icb_cmd_valid = s_icb_cmd_valid & (cmd_tgt == TGT_M1) & ~full;
        s_icb_cmd_ready  = 1'b0;
        if (!full) begin
            case (cmd_tgt)
                TGT_M0:  s_icb_cmd_ready = m0_icb_cmd_ready;
                TGT_M1:  s_icb_cmd_ready = m1_icb_cmd_ready;
                default: s_icb_cmd_ready = 1'b1;
            endcase
        end
        push = s_icb_cmd_valid & s_icb_cmd_ready;
    end

    // Response steering from the FIFO head. A slave whose response is not at
    // the head sees ready low and simply waits its turn.
    always_comb begin
        empty            = (count_q == '0);
        head             = fifo_q[rd_ptr_q];
        s_icb_rsp_valid  = 1'b0;
        s_icb_rsp_rdata  = 32'h0000_0000;
        s_icb_rsp_err    = 1'b0;
        m0_icb_rsp_ready = 1'b0;
        m1_icb_rsp_ready = 1'b0;
        if (!empty) begin
            case (head)
                TGT_M0: begin
                    s_icb_rsp_valid  = m0_icb_rsp_valid;
                    s_icb_rsp_rdata  = m0_icb_rsp_rdata;
                    s_icb_rsp_err    = m0_icb_rsp_err;
                    m0_icb_rsp_ready = s_icb_rsp_ready;
                end
                TGT_M1: begin
                    s_icb_rsp_valid  = m1_icb_rsp_valid;
                    s_icb_rsp_rdata  = m1_icb_rsp_rdata;
                    s_icb_rsp_err    = m1_icb_rsp_err;
                    m1_icb_rsp_ready = s_icb_rsp_ready;
                end
                default: begin
                    s_icb_rsp_valid  = 1'b1;
                    s_icb_rsp_err    = 1'b1;
                end
            endcase
        end
        pop = s_icb_rsp_valid & s_icb_rsp_ready;
    end

    // Target FIFO next state. Depth is a power of two, so the pointers wrap
    // naturally at their bit width.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = cmd_tgt;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers. Reset drops any outstanding entries; the slaves share
    // this reset, so no stale responses can arrive afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(outstanding_n); i++) begin
                fifo_q[i] <= TGT_M0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule

// File: tb/tb_icb_dbus_splitter.sv
// ---------------------------------------------------------------------------
// tb_icb_dbus_splitter
//
// Purpose:
//   Self-checking bench for icb_dbus_splitter. Two behavioural slaves queue
//   accepted commands and return data derived from the address. A reference
//   model keeps the expected responses in command order and predicts every
//   handshake and output each cycle. Directed scenarios come first, followed
//   by a long randomized run.
// ---------------------------------------------------------------------------
module tb_icb_dbus_splitter;

    localparam int          N        = 4;
    localparam longint      M0_BASE  = 64'h0000_0000;
    localparam longint      M0_RANGE = 16384;
    localparam longint      M1_BASE  = 64'h4000_0000;
    localparam longint      M1_RANGE = 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_icb_cmd_addr;
    logic        s_icb_cmd_read;
    logic [31:0] s_icb_cmd_wdata;
    logic [3:0]  s_icb_cmd_wmask;
    logic        s_icb_cmd_valid;
    logic        s_icb_cmd_ready;
    logic [31:0] s_icb_rsp_rdata;
    logic        s_icb_rsp_err;
    logic        s_icb_rsp_valid;
    logic        s_icb_rsp_ready;
    logic [31:0] m0_icb_cmd_addr;
    logic        m0_icb_cmd_read;
    logic [31:0] m0_icb_cmd_wdata;
    logic [3:0]  m0_icb_cmd_wmask;
    logic        m0_icb_cmd_valid;
    logic        m0_icb_cmd_ready;
    logic [31:0] m0_icb_rsp_rdata;
    logic        m0_icb_rsp_err;
    logic        m0_icb_rsp_valid;
    logic        m0_icb_rsp_ready;
    logic [31:0] m1_icb_cmd_addr;
    logic        m1_icb_cmd_read;
    logic [31:0] m1_icb_cmd_wdata;
    logic [3:0]  m1_icb_cmd_wmask;
    logic        m1_icb_cmd_valid;
    logic        m1_icb_cmd_ready;
    logic [31:0] m1_icb_rsp_rdata;
    logic        m1_icb_rsp_err;
    logic        m1_icb_rsp_valid;
    logic        m1_icb_rsp_ready;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    icb_dbus_splitter dut (
        .clk              (clk),
        .rst              (rst),
        .s_icb_cmd_addr   (s_icb_cmd_addr),
        .s_icb_cmd_read   (s_icb_cmd_read),
        .s_icb_cmd_wdata  (s_icb_cmd_wdata),
        .s_icb_cmd_wmask  (s_icb_cmd_wmask),
        .s_icb_cmd_valid  (s_icb_cmd_valid),
        .s_icb_cmd_ready  (s_icb_cmd_ready),
        .s_icb_rsp_rdata  (s_icb_rsp_rdata),
        .s_icb_rsp_err    (s_icb_rsp_err),
        .s_icb_rsp_valid  (s_icb_rsp_valid),
        .s_icb_rsp_ready  (s_icb_rsp_ready),
        .m0_icb_cmd_addr  (m0_icb_cmd_addr),
        .m0_icb_cmd_read  (m0_icb_cmd_read),
        .m0_icb_cmd_wdata (m0_icb_cmd_wdata),
        .m0_icb_cmd_wmask (m0_icb_cmd_wmask),
        .m0_icb_cmd_valid (m0_icb_cmd_valid),
        .m0_icb_cmd_ready (m0_icb_cmd_ready),
        .m0_icb_rsp_rdata (m0_icb_rsp_rdata),
        .m0_icb_rsp_err   (m0_icb_rsp_err),
        .m0_icb_rsp_valid (m0_icb_rsp_valid),
        .m0_icb_rsp_ready (m0_icb_rsp_ready),
        .m1_icb_cmd_addr  (m1_icb_cmd_addr),
        .m1_icb_cmd_read  (m1_icb_cmd_read),
        .m1_icb_cmd_wdata (m1_icb_cmd_wdata),
        .m1_icb_cmd_wmask (m1_icb_cmd_wmask),
        .m1_icb_cmd_valid (m1_icb_cmd_valid),
        .m1_icb_cmd_ready (m1_icb_cmd_ready),
        .m1_icb_rsp_rdata (m1_icb_rsp_rdata),
        .m1_icb_rsp_err   (m1_icb_rsp_err),
        .m1_icb_rsp_valid (m1_icb_rsp_valid),
        .m1_icb_rsp_ready (m1_icb_rsp_ready)
    );

    typedef struct {
        int          tgt;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t expQ[$];
    rsp_t s0q[$];
    rsp_t s1q[$];

    // Stimulus knobs written by the scenarios, applied each cycle.
    logic        resetReq   = 1'b1;
    logic        sValid     = 1'b0;
    logic [31:0] sAddr      = 32'h0;
    logic        sRead      = 1'b1;
    logic [31:0] sWdata     = 32'h0;
    logic [3:0]  sWmask     = 4'h0;
    logic        sRspReady  = 1'b0;
    logic        m0CmdReady = 1'b1;
    logic        m1CmdReady = 1'b1;
    logic        m0RspEn    = 1'b0;
    logic        m1RspEn    = 1'b0;

    bit checkEn = 1'b0;
    int checks  = 0;
    int fails   = 0;

    // Region decode with 64-bit arithmetic: base <= addr < base + range.
    function automatic int decodeTarget(input logic [31:0] a);
        longint av;
        av = longint'({32'h0, a});
        if (av >= M0_BASE && av < M0_BASE + M0_RANGE) return 0;
        if (av >= M1_BASE && av < M1_BASE + M1_RANGE) return 1;
        return 2;
    endfunction

    // Response payloads the behavioural slaves return for an address.
    function automatic rsp_t slaveRsp(input int tgt, input logic [31:0] a);
        rsp_t r;
        r.tgt = tgt;
        if (tgt == 0) begin
            r.rdata = a ^ 32'hDEAD_BEFF;
            r.err   = (a[3:2] == 2'b11);
        end else if (tgt == 1) begin
            r.rdata = ~a;
            r.err   = a[6];
        end else begin
            r.rdata = 32'h0;
            r.err   = 1'b1;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive the knobs after the edge, check every output
    // against the model mid-cycle, then advance the model to match the
    // handshakes that the coming edge will complete.
    task automatic applyStimulus();
        int   tgt;
        logic expCmdReady;
        logic expRspValid;
        logic expM0RspReady;
        logic expM1RspReady;
        rsp_t h;
        @(posedge clk);
        #1;
        rst              = resetReq;
        s_icb_cmd_valid  = sValid;
        s_icb_cmd_addr   = sAddr;
        s_icb_cmd_read   = sRead;
        s_icb_cmd_wdata  = sWdata;
        s_icb_cmd_wmask  = sWmask;
        s_icb_rsp_ready  = sRspReady;
        m0_icb_cmd_ready = m0CmdReady;
        m1_icb_cmd_ready = m1CmdReady;
        m0_icb_rsp_valid = m0RspEn && (s0q.size() > 0);
        m0_icb_rsp_rdata = (s0q.size() > 0) ? s0q[0].rdata : 32'h0;
        m0_icb_rsp_err   = (s0q.size() > 0) ? s0q[0].err : 1'b0;
        m1_icb_rsp_valid = m1RspEn && (s1q.size() > 0);
        m1_icb_rsp_rdata = (s1q.size() > 0) ? s1q[0].rdata : 32'h0;
        m1_icb_rsp_err   = (s1q.size() > 0) ? s1q[0].err : 1'b0;
        @(negedge clk);

        tgt         = decodeTarget(sAddr);
        expCmdReady = (expQ.size() < N) &&
                      ((tgt == 0) ? m0CmdReady : (tgt == 1) ? m1CmdReady : 1'b1);
        expRspValid   = 1'b0;
        expM0RspReady = 1'b0;
        expM1RspReady = 1'b0;
        h = '{tgt: 0, rdata: 32'h0, err: 1'b0};
        if (expQ.size() > 0) begin
            h = expQ[0];
            if (h.tgt == 2) begin
                expRspValid = 1'b1;
            end else if (h.tgt == 0) begin
                expRspValid   = m0_icb_rsp_valid;
                expM0RspReady = sRspReady;
            end else begin
                expRspValid   = m1_icb_rsp_valid;
                expM1RspReady = sRspReady;
            end
        end

        if (checkEn) begin
            checkOutput("s_cmd_ready", s_icb_cmd_ready, expCmdReady);
            checkOutput("m0_cmd_valid", m0_icb_cmd_valid,
                        sValid && tgt == 0 && expQ.size() < N);
            checkOutput("m1_cmd_valid", m1_icb_cmd_valid,
                        sValid && tgt == 1 && expQ.size() < N);
            checkOutput("m0_cmd_addr", m0_icb_cmd_addr, sAddr);
            checkOutput("m1_cmd_wdata", m1_icb_cmd_wdata, sWdata);
            checkOutput("m0_cmd_rdmask", {m0_icb_cmd_read, m0_icb_cmd_wmask}, {sRead, sWmask});
            checkOutput("m1_cmd_rdaddr", {m1_icb_cmd_read, m1_icb_cmd_addr[30:0]},
                        {sRead, sAddr[30:0]});
            checkOutput("s_rsp_valid", s_icb_rsp_valid, expRspValid);
            checkOutput("m0_rsp_ready", m0_icb_rsp_ready, expM0RspReady);
            checkOutput("m1_rsp_ready", m1_icb_rsp_ready, expM1RspReady);
            if (expRspValid) begin
                checkOutput("s_rsp_rdata", s_icb_rsp_rdata, h.rdata);
                checkOutput("s_rsp_err", s_icb_rsp_err, h.err);
            end
        end

        if (resetReq) begin
            expQ.delete();
            s0q.delete();
            s1q.delete();
        end else begin
            if (expRspValid && sRspReady) begin
                void'(expQ.pop_front());
                if (h.tgt == 0) void'(s0q.pop_front());
                if (h.tgt == 1) void'(s1q.pop_front());
            end
            if (sValid && expCmdReady) begin
                expQ.push_back(slaveRsp(tgt, sAddr));
                if (tgt == 0) s0q.push_back(slaveRsp(0, sAddr));
                if (tgt == 1) s1q.push_back(slaveRsp(1, sAddr));
            end
        end
    endtask

    task automatic setCmd(input logic v, input logic [31:0] a, input logic rd,
                          input logic [31:0] wd, input logic [3:0] wm);
        sValid = v;
        sAddr  = a;
        sRead  = rd;
        sWdata = wd;
        sWmask = wm;
    endtask

    // Randomized address mix, weighted towards the two regions and their edges.
    function automatic logic [31:0] randAddr();
        int          pick;
        logic [31:0] edges [6];
        edges[0] = 32'h0000_3FFF;
        edges[1] = 32'h0000_4000;
        edges[2] = 32'h4000_FFFF;
        edges[3] = 32'h4001_0000;
        edges[4] = 32'hFFFF_FFFF;
        edges[5] = 32'h3FFF_FFFF;
        pick = $urandom_range(0, 9);
        if (pick < 4) return {18'h0, 14'($urandom)};
        if (pick < 8) return {16'h4000, 16'($urandom)};
        if (pick < 9) return edges[$urandom_range(0, 5)];
        return 32'($urandom);
    endfunction

    initial begin
        // Bring the design out of reset before any checking.
        resetReq = 1'b1;
        applyStimulus();
        applyStimulus();
        resetReq = 1'b0;
        checkEn  = 1'b1;

        // Reset state: idle, ready, no responses, no slave traffic.
        setCmd(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        checkOutput("rst s_cmd_ready", s_icb_cmd_ready, 1'b1);
        checkOutput("rst s_rsp_valid", s_icb_rsp_valid, 1'b0);

        // Read to slave 0, answered one cycle later.
        sRspReady = 1'b1;
        m0RspEn   = 1'b1;
        m1RspEn   = 1'b1;
        setCmd(1'b1, 32'h0000_0010, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        checkOutput("t1 m0_valid", m0_icb_cmd_valid, 1'b1);
        checkOutput("t1 m1_valid", m1_icb_cmd_valid, 1'b0);
        setCmd(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        checkOutput("t1 rsp_valid", s_icb_rsp_valid, 1'b1);
        checkOutput("t1 rsp_rdata", s_icb_rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("t1 rsp_err", s_icb_rsp_err, 1'b0);
        applyStimulus();
        checkOutput("t1 drained", s_icb_rsp_valid, 1'b0);

        // Write to slave 1 with the payload broadcast unchanged.
        setCmd(1'b1, 32'h4000_0004, 1'b0, 32'h1234_5678, 4'b0011);
        applyStimulus();
        checkOutput("t2 m1_valid", m1_icb_cmd_valid, 1'b1);
        checkOutput("t2 m0_valid", m0_icb_cmd_valid, 1'b0);
        checkOutput("t2 m1_addr", m1_icb_cmd_addr, 32'h4000_0004);
        checkOutput("t2 m1_wdata", m1_icb_cmd_wdata, 32'h1234_5678);
        checkOutput("t2 m1_wmask", m1_icb_cmd_wmask, 4'b0011);
        setCmd(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        applyStimulus();

        // Unmapped read: error response appears the following cycle.
        setCmd(1'b1, 32'h8000_0000, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        checkOutput("t3 m0_valid", m0_icb_cmd_valid, 1'b0);
        checkOutput("t3 m1_valid", m1_icb_cmd_valid, 1'b0);
        checkOutput("t3 no early rsp", s_icb_rsp_valid, 1'b0);
        setCmd(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        checkOutput("t3 rsp_valid", s_icb_rsp_valid, 1'b1);
        checkOutput("t3 rsp_err", s_icb_rsp_err, 1'b1);
        checkOutput("t3 rsp_rdata", s_icb_rsp_rdata, 32'h0);

        // m0, m1, m0 back to back; m1 answers first and must wait its turn.
        m0RspEn = 1'b0;
        setCmd(1'b1, 32'h0000_0020, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        setCmd(1'b1, 32'h4000_0020, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        setCmd(1'b1, 32'h0000_0024, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        setCmd(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        checkOutput("t4 m1 stalled", m1_icb_rsp_ready, 1'b0);
        checkOutput("t4 no rsp", s_icb_rsp_valid, 1'b0);
        m0RspEn = 1'b1;
        applyStimulus();
        checkOutput("t4 first m0", s_icb_rsp_rdata, 32'hDEAD_BEDF);
        applyStimulus();
        checkOutput("t4 then m1", s_icb_rsp_rdata, 32'hBFFF_FFDF);
        checkOutput("t4 m1 ready", m1_icb_rsp_ready, 1'b1);
        applyStimulus();
        checkOutput("t4 last m0", s_icb_rsp_rdata, 32'hDEAD_BEDB);
        applyStimulus();

        // Fill the FIFO with stalled responses; pop does not free a slot
        // in the same cycle.
        sRspReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setCmd(1'b1, 32'h0000_0100 + 32'(4 * i), 1'b1, 32'h0, 4'h0);
            applyStimulus();
        end
        setCmd(1'b1, 32'h0000_0110, 1'b1, 32'h0, 4'h0);
        applyStimulus();
        checkOutput("t5 full", s_icb_cmd_ready, 1'b0);
        sRspReady = 1'b1;
        applyStimulus();
        checkOutput("t5 pop no push", s_icb_cmd_ready, 1'b0);
        sRspReady = 1'b0;
        applyStimulus();
        checkOutput("t5 accepted", s_icb_cmd_ready, 1'b1);
        setCmd(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
        sRspReady = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus();

        // Reset with three commands outstanding.
        m0RspEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setCmd(1'b1, 32'h0000_0200 + 32'(4 * i), 1'b1, 32'h0, 4'h0);
            applyStimulus();
        end
        setCmd(1'b0, 32'h8000_0000, 1'b1, 32'h0, 4'h0);
        resetReq = 1'b1;
        applyStimulus();
        resetReq = 1'b0;
        applyStimulus();
        checkOutput("t6 cmd_ready", s_icb_cmd_ready, 1'b1);
        checkOutput("t6 rsp_valid", s_icb_rsp_valid, 1'b0);
        checkOutput("t6 m0_rsp_ready", m0_icb_rsp_ready, 1'b0);

        // Randomized traffic against the model, with occasional resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            setCmd(1'($urandom_range(0, 2) != 0), randAddr(), 1'($urandom),
                   32'($urandom), 4'($urandom));
            sRspReady  = 1'($urandom_range(0, 3) != 0);
            m0CmdReady = 1'($urandom_range(0, 3) != 0);
            m1CmdReady = 1'($urandom_range(0, 3) != 0);
            m0RspEn    = 1'($urandom_range(0, 2) != 0);
            m1RspEn    = 1'($urandom_range(0, 2) != 0);
            resetReq   = ($urandom_range(0, 999) == 0);
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
